// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : shared types and constants for the 4x4 keypad scanner
// Revision   : 1.0
// ============================================================================
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_t;

  function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : two-flop synchronizer, resets to all-ones (idle pull-up level)
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 row-scanned keypad with frame-based debounce
// Revision       : 1.0
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_FRAMES);

  logic [3:0]    col_s;
  logic [DW-1:0] dwell;
  logic [1:0]    row_index;
  logic          tick;
  logic          frame_end;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic [2:0]    samp_zeros;
  logic [1:0]    samp_pos;
  logic [2:0]    zero_sum;
  logic [1:0]    merged_cnt;
  logic [3:0]    merged_code;
  frame_t        frame_res;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    cand;

  sync_2ff #(.WIDTH(COLS)) u_col_sync (
    .ck    (ck),
    .rst_n (rst_n),
    .d     (col),
    .q     (col_s)
  );

  assign tick      = (dwell == DWELL_LAST);
  assign frame_end = tick && (row_index == 2'd3);

  // Merge this row's sample into the running frame; zero count saturates at 2 (MULTI).
  always_comb begin
    samp_zeros = '0;
    samp_pos   = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!col_s[i]) begin
        samp_zeros = samp_zeros + 3'd1;
        samp_pos   = 2'(i);
      end
    end
    zero_sum    = {1'b0, acc_cnt} + samp_zeros;
    merged_cnt  = (zero_sum > 3'd2) ? 2'd2 : zero_sum[1:0];
    merged_code = (samp_zeros == 3'd1) ? code_of(row_index, samp_pos) : acc_code;
    if (merged_cnt == 2'd0)      frame_res = NONE;
    else if (merged_cnt == 2'd1) frame_res = SINGLE;
    else                         frame_res = MULTI;
  end

  // row trails row_index by one cycle so each row is driven for a full dwell.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      dwell     <= '0;
      row_index <= '0;
      row       <= 4'b1111;
      acc_cnt   <= '0;
      acc_code  <= '0;
    end else begin
      row <= ~(4'b0001 << row_index);
      if (tick) begin
        dwell     <= '0;
        row_index <= row_index + 2'd1;
        if (row_index == 2'd3) begin
          acc_cnt  <= '0;
          acc_code <= '0;
        end else begin
          acc_cnt  <= merged_cnt;
          acc_code <= merged_code;
        end
      end else begin
        dwell <= dwell + DWELL_ONE;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      cnt         <= '0;
      cand        <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_end) begin
        case (state)
          SCAN: begin
            if (frame_res == SINGLE) begin
              cand <= merged_code;
              if (DEBOUNCE_FRAMES == 1) begin
                state     <= PRESSED;
                key_code  <= merged_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
                cnt   <= CNT_ONE;
              end
            end
          end
          DEBOUNCE: begin
            if (frame_res == SINGLE && merged_code == cand) begin
              if (cnt + CNT_ONE == CNT_DONE) begin
                state     <= PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
              state <= SCAN;
            end
          end
          PRESSED: begin
            if (frame_res == NONE) begin
              if (DEBOUNCE_FRAMES == 1) begin
                state       <= SCAN;
                key_held    <= 1'b0;
                key_release <= 1'b1;
              end else begin
                state <= RELEASE;
                cnt   <= CNT_ONE;
              end
            end
          end
          RELEASE: begin
            if (frame_res == NONE) begin
              if (cnt + CNT_ONE == CNT_DONE) begin
                state       <= SCAN;
                key_held    <= 1'b0;
                key_release <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : directed self-checking bench, SCAN_DIV=4, 2 debounce frames
// Revision          : 1.0
// ============================================================================
module tb_keypad_scanner;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_release;

  logic [15:0] pressed = '0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int vcnt, vfirst, rcnt, rfirst;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .col         (col),
    .row         (row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  always #5 ck = ~ck;

  // Passive matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic step();
    @(posedge ck);
    cyc++;
    #1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge ck);
    #1;
  endtask

  task automatic release_reset();
    @(negedge ck);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic run(input int n);
    vcnt = 0; vfirst = -1; rcnt = 0; rfirst = -1;
    repeat (n) begin
      step();
      if (key_valid === 1'b1) begin
        if (vcnt == 0) vfirst = cyc;
        vcnt++;
      end
      if (key_release === 1'b1) begin
        if (rcnt == 0) rfirst = cyc;
        rcnt++;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    pressed = '0;
    hold_reset();
    n_cmp++;
    if ({row, key_code, key_valid, key_held, key_release} !== {4'b1111, 4'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: row=%b code=%0d v/h/r=%b%b%b, want row=1111 code=0 v/h/r=000",
               row, key_code, key_valid, key_held, key_release);
    end
    release_reset();
    repeat (40) begin
      step();
      exp_row = ~(4'b0001 << (((cyc - 1) / 4) % 4));
      n_cmp++;
      if (row !== exp_row || {key_valid, key_held, key_release} !== 3'b000) begin
        n_err++;
        $display("FAIL sweep cyc%0d: row=%b v/h/r=%b%b%b, want row=%b v/h/r=000",
                 cyc, row, key_valid, key_held, key_release, exp_row);
      end
    end
  endtask

  task automatic test_press();
    pressed = 16'h0200;
    hold_reset();
    release_reset();
    run(48);
    n_cmp++;
    if (vcnt !== 1) begin n_err++; $display("FAIL press_count: got %0d want 1", vcnt); end
    n_cmp++;
    if (vfirst !== 32) begin n_err++; $display("FAIL press_time: got %0d want 32", vfirst); end
    n_cmp++;
    if (key_code !== 4'd9 || key_held !== 1'b1) begin
      n_err++;
      $display("FAIL press_out: code=%0d held=%b want code=9 held=1", key_code, key_held);
    end
    n_cmp++;
    if (rcnt !== 0) begin n_err++; $display("FAIL press_norel: got %0d want 0", rcnt); end
  endtask

  task automatic test_release();
    pressed = '0;
    run(32);
    n_cmp++;
    if (rcnt !== 1 || rfirst !== 80) begin
      n_err++;
      $display("FAIL release_pulse: count=%0d at=%0d want count=1 at=80", rcnt, rfirst);
    end
    n_cmp++;
    if (key_held !== 1'b0 || key_code !== 4'd9 || vcnt !== 0) begin
      n_err++;
      $display("FAIL release_out: held=%b code=%0d valid=%0d want held=0 code=9 valid=0",
               key_held, key_code, vcnt);
    end
  endtask

  task automatic test_bounce();
    pressed = 16'h0040;
    hold_reset();
    release_reset();
    run(16);
    n_cmp++;
    if (vcnt !== 0) begin n_err++; $display("FAIL bounce_f0: valid=%0d want 0", vcnt); end
    pressed = '0;
    run(16);
    n_cmp++;
    if (vcnt !== 0) begin n_err++; $display("FAIL bounce_gap: valid=%0d want 0", vcnt); end
    pressed = 16'h0040;
    run(32);
    n_cmp++;
    if (vcnt !== 1 || vfirst !== 64 || key_code !== 4'd6) begin
      n_err++;
      $display("FAIL bounce_accept: count=%0d at=%0d code=%0d want count=1 at=64 code=6",
               vcnt, vfirst, key_code);
    end
  endtask

  task automatic test_multi();
    pressed = 16'h8001;
    hold_reset();
    release_reset();
    run(64);
    n_cmp++;
    if (vcnt !== 0 || key_held !== 1'b0) begin
      n_err++;
      $display("FAIL multi_hold: valid=%0d held=%b want valid=0 held=0", vcnt, key_held);
    end
    pressed = 16'h0001;
    run(32);
    n_cmp++;
    if (vcnt !== 1 || vfirst !== 96 || key_code !== 4'd0 || key_held !== 1'b1) begin
      n_err++;
      $display("FAIL multi_single: count=%0d at=%0d code=%0d held=%b want 1 at 96 code 0 held 1",
               vcnt, vfirst, key_code, key_held);
    end
  endtask

  task automatic test_mid_reset();
    pressed = 16'h0020;
    hold_reset();
    release_reset();
    run(20);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({row, key_code, key_valid, key_held, key_release} !== {4'b1111, 4'd0, 3'b000}) begin
      n_err++;
      $display("FAIL midrst_deb: row=%b code=%0d v/h/r=%b%b%b want 1111 0 000",
               row, key_code, key_valid, key_held, key_release);
    end
    release_reset();
    run(40);
    n_cmp++;
    if (vcnt !== 1 || vfirst !== 32 || key_code !== 4'd5 || key_held !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_reacc1: count=%0d at=%0d code=%0d held=%b want 1 at 32 code 5 held 1",
               vcnt, vfirst, key_code, key_held);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({row, key_code, key_valid, key_held, key_release} !== {4'b1111, 4'd0, 3'b000}) begin
      n_err++;
      $display("FAIL midrst_prs: row=%b code=%0d v/h/r=%b%b%b want 1111 0 000",
               row, key_code, key_valid, key_held, key_release);
    end
    release_reset();
    run(40);
    n_cmp++;
    if (vcnt !== 1 || vfirst !== 32 || key_code !== 4'd5) begin
      n_err++;
      $display("FAIL midrst_reacc2: count=%0d at=%0d code=%0d want 1 at 32 code 5",
               vcnt, vfirst, key_code);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_multi();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
